// File: rtl/term_tx_arbiter.sv
// Two-requester byte scheduler for the SBCTextDisplayRGB CPU port.
// A packet holds the lock until its last byte; each byte is status-polled, then strobed in.
module term_tx_arbiter #(
   parameter int POLL_LIMIT = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       r0_valid,
   input  logic [7:0] r0_data,
   input  logic       r0_last,
   output logic       r0_ready,
   input  logic       r1_valid,
   input  logic [7:0] r1_data,
   input  logic       r1_last,
   output logic       r1_ready,
   output logic       term_regSel,
   output logic       term_n_rd,
   output logic       term_n_wr,
   output logic [7:0] term_wdata,
   input  logic [7:0] term_rdata,
   output logic       owner,
   output logic       locked,
   output logic       busy,
   output logic       err
);
   localparam int CW = $clog2(POLL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(POLL_LIMIT);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_SET, S_WR, S_HOLD} state_t;

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          locked_q, locked_d;
   logic          owner_q, owner_d;
   logic          err_q, err_d;
   logic [7:0]    byte_q, byte_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          nb_q, nb_d;
   logic          regsel_q, regsel_d;
   logic          n_rd_q, n_rd_d;
   logic          n_wr_q, n_wr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          gnt0, gnt1;
   logic          unused_rdata;

   // Handshake: a byte moves in the cycle where rX_valid and rX_ready are both high;
   // ready is raised only in IDLE, only for the granted requester, for that single cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      locked_d = locked_q;
      owner_d  = owner_q;
      err_d    = err_q;
      byte_d   = byte_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      nb_d     = nb_q;
      wdata_d  = wdata_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (locked_q) begin
               gnt0 = !owner_q && r0_valid;
               gnt1 = owner_q && r1_valid;
            end else if (r0_valid && r1_valid) begin
               gnt0 = !ptr_q;
               gnt1 = ptr_q;
            end else begin
               gnt0 = r0_valid;
               gnt1 = r1_valid;
            end
            if (gnt0 || gnt1) begin
               byte_d   = gnt1 ? r1_data : r0_data;
               last_d   = gnt1 ? r1_last : r0_last;
               locked_d = 1'b1;
               owner_d  = gnt1;
               cnt_d    = '0;
               state_d  = S_RD;
            end
         end
         S_RD: begin
            nb_d = term_rdata[1];
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
            state_d = S_CHK;
         end
         S_CHK: begin
            if (nb_q) begin
               wdata_d = byte_q;
               state_d = S_SET;
            end else if (cnt_q < LIMIT) begin
               state_d = S_RD;
            end else begin
               // Timed-out byte is dropped but still closes its packet if it was the last one.
               err_d   = 1'b1;
               state_d = S_IDLE;
               if (last_q) begin
                  locked_d = 1'b0;
                  ptr_d    = ~owner_q;
               end
            end
         end
         S_SET:   state_d = S_WR;
         S_WR:    state_d = S_HOLD;
         S_HOLD: begin
            if (last_q) begin
               locked_d = 1'b0;
               ptr_d    = ~owner_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Strobes are registered from the next state so they are glitch-free and one cycle wide.
      regsel_d = (state_d == S_SET) || (state_d == S_WR) || (state_d == S_HOLD);
      n_rd_d   = (state_d != S_RD);
      n_wr_d   = (state_d != S_WR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= 1'b0;
         locked_q <= 1'b0;
         owner_q  <= 1'b0;
         err_q    <= 1'b0;
         byte_q   <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         nb_q     <= 1'b0;
         regsel_q <= 1'b0;
         n_rd_q   <= 1'b1;
         n_wr_q   <= 1'b1;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         locked_q <= locked_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
         byte_q   <= byte_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         nb_q     <= nb_d;
         regsel_q <= regsel_d;
         n_rd_q   <= n_rd_d;
         n_wr_q   <= n_wr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign r0_ready     = gnt0 && !reset;
   assign r1_ready     = gnt1 && !reset;
   assign term_regSel  = regsel_q;
   assign term_n_rd    = n_rd_q;
   assign term_n_wr    = n_wr_q;
   assign term_wdata   = wdata_q;
   assign owner        = owner_q;
   assign locked       = locked_q;
   assign busy         = (state_q != S_IDLE);
   assign err          = err_q;
   assign unused_rdata = ^{term_rdata[7:2], term_rdata[0]};
endmodule
